// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
//   OAM DMA engine. Snoops CPU writes to the DMA register and copies NUM_BYTES
//   bytes from {hi,8'h00}.. into sprite OAM, one source read per cycle.
//
//   Ports
//     iClock          system clock, rising edge
//     iReset          asynchronous, active-low reset
//     iCpuWe          CPU write strobe
//     iCpuAddr        CPU address
//     iCpuData        CPU write data
//     oDmaReg         last value written to DMA_REG_ADDR (readback)
//     oDmaActive      transfer in progress (START/XFER/DRAIN)
//     oSrcReadRequest source read strobe
//     oSrcAddr        source address {hi,idx}, zero when not reading
//     iSrcData        source data, valid RD_LATENCY cycles after the address
//     oOamWe          OAM write enable
//     oOamAddr        OAM offset 0..NUM_BYTES-1 (MMU adds 0xFE00)
//     oOamData        OAM write data (iSrcData while oOamWe=1, else 0)
// -----------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter int          NUM_BYTES    = 160,
    parameter int          RD_LATENCY   = 1,
    parameter int          START_DELAY  = 1
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iCpuWe,
    input  logic [15:0] iCpuAddr,
    input  logic [7:0]  iCpuData,
    output logic [7:0]  oDmaReg,
    output logic        oDmaActive,
    output logic        oSrcReadRequest,
    output logic [15:0] oSrcAddr,
    input  logic [7:0]  iSrcData,
    output logic        oOamWe,
    output logic [7:0]  oOamAddr,
    output logic [7:0]  oOamData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_XFER  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] LAST_IDX   = 8'(NUM_BYTES - 1);
    localparam logic [7:0] START_LAST = 8'(START_DELAY - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(RD_LATENCY - 1);

    // Source pages 0xE0..0xFF mirror work RAM 0xC0..0xDF (echo RAM).
    function automatic logic [7:0] echo_alias(input logic [7:0] page);
        if (page >= 8'hE0) begin
            return page - 8'h20;
        end else begin
            return page;
        end
    endfunction

    state_t                          state_q, state_d;
    logic [7:0]                      cnt_q, cnt_d;
    logic [7:0]                      idx_q, idx_d;
    logic [7:0]                      hi_q, hi_d;
    logic [7:0]                      reg_q, reg_d;
    logic                            req_q, req_d;
    logic [15:0]                     addr_q, addr_d;
    logic                            active_q, active_d;
    logic [RD_LATENCY-1:0]           pipe_v_q, pipe_v_d;
    logic [RD_LATENCY-1:0][7:0]      pipe_idx_q, pipe_idx_d;
    logic                            trigger_s;

    assign trigger_s = iCpuWe && (iCpuAddr == DMA_REG_ADDR);

    // Next-state, counters and registered source-port values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        reg_d   = reg_q;
        req_d   = 1'b0;
        addr_d  = 16'h0000;
        if (trigger_s) begin
            // Fresh trigger and retrigger behave the same: restart from START.
            reg_d   = iCpuData;
            hi_d    = echo_alias(iCpuData);
            state_d = S_START;
            cnt_d   = 8'd0;
            idx_d   = 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_START: begin
                    if (cnt_q == START_LAST) begin
                        state_d = S_XFER;
                        idx_d   = 8'd0;
                        req_d   = 1'b1;
                        addr_d  = {hi_q, 8'h00};
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_XFER: begin
                    // idx_q is the index currently on oSrcAddr.
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                        cnt_d   = 8'd0;
                    end else begin
                        idx_d  = idx_q + 8'd1;
                        req_d  = 1'b1;
                        addr_d = {hi_q, idx_q + 8'd1};
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        active_d = (state_d != S_IDLE);
    end

    // Read pipeline: tracks which index each in-flight read belongs to.
    always_comb begin
        pipe_v_d   = pipe_v_q;
        pipe_idx_d = pipe_idx_q;
        if (trigger_s) begin
            // Flush: reads already issued for the old transfer are dropped.
            pipe_v_d   = '0;
            pipe_idx_d = '0;
        end else begin
            pipe_v_d[0]   = req_q;
            pipe_idx_d[0] = req_q ? idx_q : 8'h00;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_v_d[i]   = pipe_v_q[i-1];
                pipe_idx_d[i] = pipe_idx_q[i-1];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            idx_q      <= 8'd0;
            hi_q       <= 8'h00;
            reg_q      <= 8'h00;
            req_q      <= 1'b0;
            addr_q     <= 16'h0000;
            active_q   <= 1'b0;
            pipe_v_q   <= '0;
            pipe_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            hi_q       <= hi_d;
            reg_q      <= reg_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            active_q   <= active_d;
            pipe_v_q   <= pipe_v_d;
            pipe_idx_q <= pipe_idx_d;
        end
    end

    assign oDmaReg         = reg_q;
    assign oDmaActive      = active_q;
    assign oSrcReadRequest = req_q;
    assign oSrcAddr        = addr_q;
    assign oOamWe          = pipe_v_q[RD_LATENCY-1];
    assign oOamAddr        = pipe_idx_q[RD_LATENCY-1];
    // Source data is combinational into OAM; gated so idle cycles show 0.
    assign oOamData        = oOamWe ? iSrcData : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
//   Two instances (RD_LATENCY=1 and RD_LATENCY=3) share the CPU bus. A
//   schedule model derives every output from the latest trigger edge.
// -----------------------------------------------------------------------------
module tb_oam_dma;

    localparam int NB = 160;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;

    logic [7:0]  reg1, reg3;
    logic        act1, act3, req1, req3, we1, we3;
    logic [15:0] sa1, sa3;
    logic [7:0]  sd1, sd3, oa1, oa3, od1, od3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    oam_dma #(.RD_LATENCY(1)) u1 (
        .iClock(clk), .iReset(rst_n), .iCpuWe(cpu_we), .iCpuAddr(cpu_addr),
        .iCpuData(cpu_data), .oDmaReg(reg1), .oDmaActive(act1),
        .oSrcReadRequest(req1), .oSrcAddr(sa1), .iSrcData(sd1),
        .oOamWe(we1), .oOamAddr(oa1), .oOamData(od1)
    );

    oam_dma #(.RD_LATENCY(3)) u3 (
        .iClock(clk), .iReset(rst_n), .iCpuWe(cpu_we), .iCpuAddr(cpu_addr),
        .iCpuData(cpu_data), .oDmaReg(reg3), .oDmaActive(act3),
        .oSrcReadRequest(req3), .oSrcAddr(sa3), .iSrcData(sd3),
        .oOamWe(we3), .oOamAddr(oa3), .oOamData(od3)
    );

    // Source memory contents: C0xx holds xx^5A; other pages are distinct.
    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC0;
    endfunction

    // Source memories with 1 and 3 cycles of read latency.
    logic [15:0] s1_a;
    logic        s1_v;
    logic [15:0] s3_a [3];
    logic        s3_v [3];
    always @(posedge clk) begin
        s1_a    <= sa1;
        s1_v    <= req1;
        s3_a[0] <= sa3;
        s3_v[0] <= req3;
        s3_a[1] <= s3_a[0];
        s3_v[1] <= s3_v[0];
        s3_a[2] <= s3_a[1];
        s3_v[2] <= s3_v[1];
    end
    assign sd1 = (s1_v === 1'b1) ? src_byte(s1_a) : 8'hA5;
    assign sd3 = (s3_v[2] === 1'b1) ? src_byte(s3_a[2]) : 8'hA5;

    // Model state: edge count, edge of latest trigger, register and page.
    int         edge_n = 0;
    int         t_trig = 0;
    bit         t_valid = 1'b0;
    logic [7:0] m_reg = 8'h00;
    logic [7:0] m_hi  = 8'h00;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_valid <= 1'b0;
            m_reg   <= 8'h00;
            m_hi    <= 8'h00;
        end else begin
            edge_n <= edge_n + 1;
            if (cpu_we && cpu_addr == 16'hFF46) begin
                t_valid <= 1'b1;
                t_trig  <= edge_n + 1;
                m_reg   <= cpu_data;
                m_hi    <= (cpu_data >= 8'hE0) ? cpu_data - 8'h20 : cpu_data;
            end
        end
    end

    // k = cycles since trigger edge: active 1..161+L, read i at 2+i, write at 2+i+L.
    task automatic model_out(input int lat, output logic act, output logic req,
                             output logic [15:0] sa, output logic we,
                             output logic [7:0] oa, output logic [7:0] od);
        int k;
        act = 1'b0; req = 1'b0; sa = 16'h0000; we = 1'b0; oa = 8'h00; od = 8'h00;
        if (t_valid && rst_n === 1'b1) begin
            k = edge_n + 1 - t_trig;
            if (k >= 1 && k <= NB + 1 + lat) act = 1'b1;
            if (k >= 2 && k <= NB + 1) begin
                req = 1'b1;
                sa  = {m_hi, 8'(k - 2)};
            end
            if (k >= 2 + lat && k <= NB + 1 + lat) begin
                we = 1'b1;
                oa = 8'(k - 2 - lat);
                od = src_byte({m_hi, oa});
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
        end
    endtask

    logic        e_act, e_req, e_we;
    logic [15:0] e_sa;
    logic [7:0]  e_oa, e_od;

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        model_out(1, e_act, e_req, e_sa, e_we, e_oa, e_od);
        chk("u1.reg", reg1, m_reg);
        chk("u1.active", act1, e_act);
        chk("u1.req", req1, e_req);
        chk("u1.src_addr", sa1, e_sa);
        chk("u1.oam_we", we1, e_we);
        chk("u1.oam_addr", oa1, e_oa);
        chk("u1.oam_data", od1, e_od);
        model_out(3, e_act, e_req, e_sa, e_we, e_oa, e_od);
        chk("u3.reg", reg3, m_reg);
        chk("u3.active", act3, e_act);
        chk("u3.req", req3, e_req);
        chk("u3.src_addr", sa3, e_sa);
        chk("u3.oam_we", we3, e_we);
        chk("u3.oam_addr", oa3, e_oa);
        chk("u3.oam_data", od3, e_od);
    end

    // Called at a negedge; the write is sampled on the following posedge T,
    // and the task returns at the sample of cycle T+1.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_we   = 1'b1;
        cpu_addr = a;
        cpu_data = d;
        @(negedge clk);
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_data = 8'h00;
    endtask

    bit found;

    initial begin
        rst_n    = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = 16'h0000;
        cpu_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst.active", act1, 1'b0);
        chk("rst.oam_we", we1, 1'b0);
        chk("rst.src_addr", sa1, 16'h0000);
        chk("rst.reg", reg3, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Non-trigger accesses: other registers and reads of FF46.
        cpu_write(16'hFF45, 8'hC0);
        cpu_write(16'hFF47, 8'hC0);
        cpu_addr = 16'hFF46;
        cpu_data = 8'hC0;
        repeat (3) @(negedge clk);
        cpu_addr = 16'h0000;
        cpu_data = 8'h00;
        repeat (2) @(negedge clk);
        chk("t6.active", act1, 1'b0);
        chk("t6.reg", reg1, 8'h00);

        // Basic transfer from page C0; u3 covers the latency-3 timing.
        cpu_write(16'hFF46, 8'hC0);                   // T+1
        chk("t1.reg", reg1, 8'hC0);
        chk("t1.active", act1, 1'b1);
        chk("t1.no_read_in_start", req1, 1'b0);
        @(negedge clk);                               // T+2
        chk("t1.first_addr", sa1, 16'hC000);
        chk("t1.no_write_yet", we1, 1'b0);
        @(negedge clk);                               // T+3
        chk("t1.first_we", we1, 1'b1);
        chk("t1.first_data", od1, 8'h5A);
        repeat (159) @(negedge clk);                  // T+162
        chk("t1.last_addr", oa1, 8'h9F);
        chk("t1.last_data", od1, 8'hC5);
        chk("t5.oa_T162", oa3, 8'h9D);
        @(negedge clk);                               // T+163
        chk("t1.inactive", act1, 1'b0);
        chk("t5.still_active", act3, 1'b1);
        @(negedge clk);                               // T+164
        chk("t5.last_addr", oa3, 8'h9F);
        chk("t5.last_data", od3, 8'hC5);
        @(negedge clk);                               // T+165
        chk("t5.inactive", act3, 1'b0);
        repeat (4) @(negedge clk);

        // Echo-RAM page.
        cpu_write(16'hFF46, 8'hE1);
        chk("t2.reg", reg1, 8'hE1);
        @(negedge clk);
        chk("t2.first_addr", sa1, 16'hC100);
        @(negedge clk);
        chk("t2.first_data", od1, 8'h5B);
        repeat (170) @(negedge clk);

        // Retrigger while the write of index 50 is on the outputs.
        cpu_write(16'hFF46, 8'h80);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (we1 === 1'b1 && oa1 === 8'd50) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t3.reached_50", found, 1'b1);
        chk("t3.data_50", od1, 8'h28);
        cpu_write(16'hFF46, 8'h90);                   // T'+1
        chk("t3.flushed", we1, 1'b0);
        chk("t3.reg", reg1, 8'h90);
        @(negedge clk);                               // T'+2
        chk("t3.restart_addr", sa1, 16'h9000);
        repeat (170) @(negedge clk);

        // Reset mid-transfer.
        cpu_write(16'hFF46, 8'hC0);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (req1 === 1'b1 && sa1[7:0] === 8'd80) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t4.reached_80", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4.reg", reg1, 8'h00);
        chk("t4.active", act1, 1'b0);
        chk("t4.req", req1, 1'b0);
        chk("t4.src_addr", sa1, 16'h0000);
        chk("t4.oam_we", we1, 1'b0);
        chk("t4.oam_addr", oa1, 8'h00);
        chk("t4.oam_data", od1, 8'h00);
        chk("t4.u3_active", act3, 1'b0);
        chk("t4.u3_oam_we", we3, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        chk("t4.idle_after", act1, 1'b0);

        // A new register write starts a transfer again.
        cpu_write(16'hFF46, 8'hC0);
        chk("t4.restart", act1, 1'b1);
        repeat (170) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
